// File: rtl/adder_serial_nibble_pkg.sv
// Shared definitions for the nibble-serial adder: FSM encodings and slice width.
// Imported by adder_serial_nibble and its adder_4bits slice.
package adder_serial_nibble_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Counter width for a given nibble count, never narrower than one bit.
  function automatic int cnt_width(input int nibbles);
    return (nibbles > 1) ? $clog2(nibbles) : 1;
  endfunction

endpackage

// File: rtl/adder_serial_nibble_adder_4bits.sv
// Combinational 4-bit ripple slice: {o_w_cout, o_w_sum} = a + b + cin.
// The serial adder evaluates one operand nibble per clock through this slice.
module adder_4bits
  import adder_serial_nibble_pkg::*;
(
  input  logic [NIBBLE_W-1:0] i_w_a,
  input  logic [NIBBLE_W-1:0] i_w_b,
  input  logic                i_w_cin,
  output logic [NIBBLE_W-1:0] o_w_sum,
  output logic                o_w_cout
);

  logic [NIBBLE_W:0] w_total;

  assign w_total  = {1'b0, i_w_a} + {1'b0, i_w_b} + {{NIBBLE_W{1'b0}}, i_w_cin};
  assign o_w_sum  = w_total[NIBBLE_W-1:0];
  assign o_w_cout = w_total[NIBBLE_W];

endmodule

// File: rtl/adder_serial_nibble.sv
// WIDTH-bit adder that feeds one adder_4bits slice a nibble per clock, LSB first,
// with a start/busy/done handshake. Optional signed overflow output: ADDER_SERIAL_OVF_EN.
module adder_serial_nibble
  import adder_serial_nibble_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             i_w_clk,
  input  logic             i_w_reset,
  input  logic             i_w_start,
  input  logic [WIDTH-1:0] i_w_a,
  input  logic [WIDTH-1:0] i_w_b,
  input  logic             i_w_cin,
  output logic [WIDTH-1:0] o_w_sum,
  output logic             o_w_cout,
  output logic             o_w_busy,
`ifdef ADDER_SERIAL_OVF_EN
  output logic             o_w_ovf,
`endif
  output logic             o_w_done
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int CNT_W   = cnt_width(NIBBLES);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIBBLES - 1);

  state_t             r_state;
  state_t             w_state_next;
  logic               w_accept;
  logic               w_last;

  logic [WIDTH-1:0]   r_a_sh;
  logic [WIDTH-1:0]   r_b_sh;
  logic [WIDTH-1:0]   r_psum;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;
  logic               r_done;

  logic [NIBBLE_W-1:0] w_slice_sum;
  logic                w_slice_cout;
  logic [WIDTH-1:0]    w_psum_next;

  adder_4bits u_slice (
    .i_w_a    (r_a_sh[NIBBLE_W-1:0]),
    .i_w_b    (r_b_sh[NIBBLE_W-1:0]),
    .i_w_cin  (r_carry),
    .o_w_sum  (w_slice_sum),
    .o_w_cout (w_slice_cout)
  );

  // New nibble enters at the MSB end so the LSB nibble lands at bit 0 after the last step.
  generate
    if (NIBBLES == 1) begin : g_single
      assign w_psum_next = w_slice_sum;
    end else begin : g_multi
      assign w_psum_next = {w_slice_sum, r_psum[WIDTH-1:NIBBLE_W]};
    end
  endgenerate

  always_ff @(posedge i_w_clk or posedge i_w_reset) begin
    if (i_w_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_w_start) begin
          w_accept     = 1'b1;
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (r_cnt == LAST_CNT) begin
          w_last       = 1'b1;
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_w_clk or posedge i_w_reset) begin
    if (i_w_reset) begin
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_psum  <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_last;
      if (w_accept) begin
        r_a_sh  <= i_w_a;
        r_b_sh  <= i_w_b;
        r_psum  <= '0;
        r_carry <= i_w_cin;
        r_cnt   <= '0;
      end else if (r_state == ST_RUN) begin
        r_a_sh  <= r_a_sh >> NIBBLE_W;
        r_b_sh  <= r_b_sh >> NIBBLE_W;
        r_psum  <= w_psum_next;
        r_carry <= w_slice_cout;
        r_cnt   <= r_cnt + 1'b1;
      end
      if (w_last) begin
        r_sum  <= w_psum_next;
        r_cout <= w_slice_cout;
      end
    end
  end

`ifdef ADDER_SERIAL_OVF_EN
  logic r_ovf;

  // On the last step the shift registers hold the operand MSB nibbles.
  always_ff @(posedge i_w_clk or posedge i_w_reset) begin
    if (i_w_reset) begin
      r_ovf <= 1'b0;
    end else if (w_last) begin
      r_ovf <= (r_a_sh[NIBBLE_W-1] == r_b_sh[NIBBLE_W-1]) &&
               (w_slice_sum[NIBBLE_W-1] != r_a_sh[NIBBLE_W-1]);
    end
  end

  assign o_w_ovf = r_ovf;
`endif

  assign o_w_sum  = r_sum;
  assign o_w_cout = r_cout;
  assign o_w_busy = (r_state == ST_RUN);
  assign o_w_done = r_done;

endmodule

// File: tb/tb_adder_serial_nibble.sv
// Directed bench for adder_serial_nibble: WIDTH=16 vector table, start-during-run,
// mid-run reset, and an exhaustive WIDTH=4 sweep on a second instance.
module tb_adder_serial_nibble;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic [15:0] sum;
  logic        cout, busy, done;

  logic        start4 = 1'b0;
  logic [3:0]  a4 = '0;
  logic [3:0]  b4 = '0;
  logic        cin4 = 1'b0;
  logic [3:0]  sum4;
  logic        cout4, busy4, done4;

`ifdef ADDER_SERIAL_OVF_EN
  logic ovf, ovf4;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  adder_serial_nibble #(.WIDTH(16)) dut (
    .i_w_clk(clk), .i_w_reset(rst), .i_w_start(start),
    .i_w_a(a), .i_w_b(b), .i_w_cin(cin),
    .o_w_sum(sum), .o_w_cout(cout), .o_w_busy(busy),
`ifdef ADDER_SERIAL_OVF_EN
    .o_w_ovf(ovf),
`endif
    .o_w_done(done)
  );

  adder_serial_nibble #(.WIDTH(4)) dut4 (
    .i_w_clk(clk), .i_w_reset(rst), .i_w_start(start4),
    .i_w_a(a4), .i_w_b(b4), .i_w_cin(cin4),
    .o_w_sum(sum4), .o_w_cout(cout4), .o_w_busy(busy4),
`ifdef ADDER_SERIAL_OVF_EN
    .o_w_ovf(ovf4),
`endif
    .o_w_done(done4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Start one WIDTH=16 op, scramble operands after acceptance, check latency/busy/result.
  task automatic run16(input vec_t v);
    int cyc, busy_cnt;
    @(negedge clk);
    a = v.a; b = v.b; cin = v.cin; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; a = ~v.a; b = ~v.b; cin = ~v.cin;
    busy_cnt = busy ? 1 : 0;
    cyc = 0;
    while (!done && cyc < 20) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
      if (!done && busy) busy_cnt++;
    end
    check("latency", cyc, 4);
    check("busy_cycles", busy_cnt, 4);
    check("sum", {16'h0, sum}, {16'h0, v.sum});
    check("cout", {31'h0, cout}, {31'h0, v.cout});
`ifdef ADDER_SERIAL_OVF_EN
    check("ovf", {31'h0, ovf}, {31'h0, v.ovf});
`endif
    @(negedge clk);
    check("done_pulse_end", {31'h0, done}, 32'h0);
    check("sum_hold", {16'h0, sum}, {16'h0, v.sum});
  endtask

  task automatic run4(input logic [3:0] va, input logic [3:0] vb, input logic vc);
    int cyc;
    logic [4:0] exp;
    exp = {1'b0, va} + {1'b0, vb} + {4'b0, vc};
    @(negedge clk);
    a4 = va; b4 = vb; cin4 = vc; start4 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start4 = 1'b0;
    cyc = 0;
    while (!done4 && cyc < 10) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    check("w4_latency", cyc, 1);
    check("w4_result", {27'h0, cout4, sum4}, {27'h0, exp});
    @(negedge clk);
  endtask

  initial begin
    vec_t vecs[11];
    int done_cnt;

    vecs[0]  = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1]  = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2]  = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[3]  = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[4]  = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[5]  = '{16'hABCD, 16'h1234, 1'b1, 16'hBE02, 1'b0, 1'b0};
    vecs[6]  = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[7]  = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[8]  = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[9]  = '{16'h8000, 16'hFFFF, 1'b0, 16'h7FFF, 1'b1, 1'b1};
    vecs[10] = '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0};

    #2;
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_sum", {16'h0, sum}, 32'h0);
    check("rst_cout", {31'h0, cout}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) run16(vecs[i]);

    // Start pulsed during RUN must be dropped.
    @(negedge clk);
    a = 16'h1234; b = 16'h4321; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    a = 16'h1111; b = 16'h1111; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 10; k++) begin
      if (done) done_cnt++;
      @(negedge clk);
    end
    check("drop_done_count", done_cnt, 1);
    check("drop_sum", {16'h0, sum}, 32'h5555);

    // Reset in the middle of RUN aborts and clears everything.
    @(negedge clk);
    a = 16'hFFFF; b = 16'h0001; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", {31'h0, busy}, 32'h0);
    check("midrst_done", {31'h0, done}, 32'h0);
    check("midrst_sum", {16'h0, sum}, 32'h0);
    check("midrst_cout", {31'h0, cout}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("midrst_no_done", done_cnt, 0);
    run16(vecs[3]);

    for (int ia = 0; ia < 16; ia++)
      for (int ib = 0; ib < 16; ib++)
        for (int ic = 0; ic < 2; ic++)
          run4(4'(ia), 4'(ib), 1'(ic));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
